// File: rtl/i2c_slave_tx.sv
// I2C read-direction slave: answers a matching read address with ACK, then
// serialises tx_data bytes MSB first until the master NACKs or issues STOP.
module i2c_slave_tx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    input  logic [7:0] tx_data,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       tx_ack,
    output logic       nack_seen,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        TX_BYTE   = 4'd3,
        WAIT_ACK  = 4'd4,
        WAIT_STOP = 4'd5
    } state_t;

    state_t     st;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic [7:0] addr_shift;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       armed;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign sda_out = 1'b0;
    assign state   = st;

    // Synchronisers preset to the idle-bus level so leaving reset cannot fake a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = sda_prev & ~sda_s & scl_s;
    assign stop_det  = ~sda_prev & sda_s & scl_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            sda_oe     <= 1'b0;
            tx_ack     <= 1'b0;
            nack_seen  <= 1'b0;
            busy       <= 1'b0;
            addr_shift <= '0;
            tx_shift   <= '0;
            bit_cnt    <= '0;
            armed      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so every branch below only raises them.
            tx_ack    <= 1'b0;
            nack_seen <= 1'b0;
            if (stop_det) begin
                st     <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                armed  <= 1'b0;
            end else if (start_det) begin
                st      <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                armed   <= 1'b0;
            end else begin
                case (st)
                    IDLE: ;
                    ADDR: begin
                        // armed marks "8 bits in, act on the next falling edge".
                        if (scl_rise && !armed) begin
                            addr_shift <= {addr_shift[6:0], sda_s};
                            bit_cnt    <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                armed <= 1'b1;
                        end else if (scl_fall && armed) begin
                            armed <= 1'b0;
                            if (addr_shift == {SLAVE_ADDR, 1'b1}) begin
                                sda_oe   <= 1'b1;
                                tx_shift <= tx_data;
                                tx_ack   <= 1'b1;
                                busy     <= 1'b1;
                                st       <= ADDR_ACK;
                            end else begin
                                st <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= ~tx_shift[7];
                            bit_cnt <= '0;
                            st      <= TX_BYTE;
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                st      <= WAIT_ACK;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sda_oe   <= ~tx_shift[6];
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                nack_seen <= 1'b1;
                                busy      <= 1'b0;
                                st        <= WAIT_STOP;
                            end else begin
                                armed <= 1'b1;
                            end
                        end else if (scl_fall && armed) begin
                            armed    <= 1'b0;
                            tx_shift <= tx_data;
                            tx_ack   <= 1'b1;
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= '0;
                            st       <= TX_BYTE;
                        end
                    end
                    WAIT_STOP: ;
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx.sv
// Bench for i2c_slave_tx: a bit-banged master drives SCL/SDA on the falling
// clk edge; a table of read/write transactions plus hand-written corner cases.
module tb_i2c_slave_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda;
    logic       sda_bus;
    logic [7:0] tx_data;
    logic       sda_out, sda_oe, tx_ack, nack_seen, busy;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int tx_ack_cnt = 0;
    int nack_cnt = 0;
    int oe_glitch = 0;
    logic oe_prev = 1'b0;

    logic [3:0] smp_state;
    logic       smp_oe, smp_busy;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       match;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_tx #(.SLAVE_ADDR(7'h50)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_bus),
        .tx_data   (tx_data),
        .sda_out   (sda_out),
        .sda_oe    (sda_oe),
        .tx_ack    (tx_ack),
        .nack_seen (nack_seen),
        .busy      (busy),
        .state     (state)
    );

    // Pulse counters and a watch for the slave touching SDA while SCL is high.
    always @(negedge clk) begin
        if (tx_ack)    tx_ack_cnt++;
        if (nack_seen) nack_cnt++;
        if (scl && !reset && sda_oe !== oe_prev) oe_glitch++;
        oe_prev = sda_oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic m, output logic seen);
        m_sda = m;
        tick(7);
        scl = 1'b1;
        tick(4);
        seen      = sda_bus;
        smp_state = state;
        smp_oe    = sda_oe;
        smp_busy  = busy;
        tick(4);
        scl = 1'b0;
        tick(1);
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(6);
        m_sda = 1'b0;
        tick(6);
        scl = 1'b0;
        tick(2);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(6);
        m_sda = 1'b1;
        tick(6);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] got);
        logic s;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            v[i] = s;
        end
        check("busy_in_byte", smp_busy, 1'b1);
        clock_bit(~master_ack, s);
        check("oe_released_in_ack_slot", smp_oe, 1'b0);
        got = v;
    endtask

    initial begin
        logic       s;
        logic [7:0] got;
        logic [3:0] nib;
        int         a0, n0;

        vecs[0] = '{addr: 8'hA1, data: 8'h5A, match: 1'b1};
        vecs[1] = '{addr: 8'hA0, data: 8'h77, match: 1'b0};
        vecs[2] = '{addr: 8'hA3, data: 8'h77, match: 1'b0};
        vecs[3] = '{addr: 8'hA1, data: 8'hFF, match: 1'b1};
        vecs[4] = '{addr: 8'hA1, data: 8'h00, match: 1'b1};

        reset = 1'b1; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
        tick(4);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_sda_out", sda_out, 1'b0);
        check("rst_tx_ack", tx_ack, 1'b0);
        check("rst_nack", nack_seen, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state, 4'd0);
        reset = 1'b0;
        tick(4);

        // Table of single-byte transactions, each ended by master NACK + STOP.
        for (int k = 0; k < 5; k++) begin
            a0 = tx_ack_cnt; n0 = nack_cnt;
            tx_data = vecs[k].data;
            bus_start();
            check("start_to_addr", state, 4'd1);
            send_byte(vecs[k].addr);
            clock_bit(1'b1, s);
            check("addr_ack_level", s, vecs[k].match ? 1'b0 : 1'b1);
            check("ack_slot_state", smp_state, vecs[k].match ? 4'd2 : 4'd5);
            if (vecs[k].match) begin
                read_byte(1'b0, got);
                check("read_byte", got, vecs[k].data);
                check("nack_pulses", nack_cnt - n0, 1);
                check("state_after_nack", state, 4'd5);
                check("busy_after_nack", busy, 1'b0);
            end
            check("tx_ack_pulses", tx_ack_cnt - a0, vecs[k].match ? 1 : 0);
            bus_stop();
            check("stop_to_idle", state, 4'd0);
        end

        // Two bytes: master ACKs 0x3C, then NACKs 0xC5.
        a0 = tx_ack_cnt; n0 = nack_cnt;
        tx_data = 8'h3C;
        bus_start();
        send_byte(8'hA1);
        clock_bit(1'b1, s);
        check("two_byte_addr_ack", s, 1'b0);
        check("two_byte_first_ack", tx_ack_cnt - a0, 1);
        tx_data = 8'hC5;
        read_byte(1'b1, got);
        check("two_byte_b0", got, 8'h3C);
        check("no_nack_on_ack", nack_cnt - n0, 0);
        read_byte(1'b0, got);
        check("two_byte_b1", got, 8'hC5);
        check("two_byte_tx_acks", tx_ack_cnt - a0, 2);
        check("two_byte_nack", nack_cnt - n0, 1);
        check("two_byte_wait_stop", state, 4'd5);
        bus_stop();
        check("two_byte_idle", state, 4'd0);
        check("two_byte_busy", busy, 1'b0);

        // Repeated START while the slave is mid-byte (bit 3 of 0x3C is a 1).
        tx_data = 8'h3C;
        bus_start();
        send_byte(8'hA1);
        clock_bit(1'b1, s);
        for (int i = 3; i >= 0; i--) begin
            clock_bit(1'b1, s);
            nib[i] = s;
        end
        check("rs_first_nibble", nib, 4'h3);
        check("rs_in_tx_byte", state, 4'd3);
        bus_start();
        check("rs_state_addr", state, 4'd1);
        check("rs_sda_released", sda_oe, 1'b0);
        a0 = tx_ack_cnt;
        tx_data = 8'h96;
        send_byte(8'hA1);
        clock_bit(1'b1, s);
        check("rs_addr_ack", s, 1'b0);
        read_byte(1'b0, got);
        check("rs_read_byte", got, 8'h96);
        check("rs_tx_ack", tx_ack_cnt - a0, 1);
        bus_stop();

        // Reset while driving a 0 bit, then a clean transaction.
        tx_data = 8'h00;
        bus_start();
        send_byte(8'hA1);
        clock_bit(1'b1, s);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        tick(6);
        check("pre_reset_driving", sda_oe, 1'b1);
        reset = 1'b1;
        tick(1);
        check("reset_releases_sda", sda_oe, 1'b0);
        check("reset_state_idle", state, 4'd0);
        reset = 1'b0;
        tick(4);
        bus_stop();
        a0 = tx_ack_cnt;
        tx_data = 8'h69;
        bus_start();
        send_byte(8'hA1);
        clock_bit(1'b1, s);
        check("post_reset_ack", s, 1'b0);
        read_byte(1'b0, got);
        check("post_reset_byte", got, 8'h69);
        check("post_reset_tx_ack", tx_ack_cnt - a0, 1);
        bus_stop();
        check("post_reset_idle", state, 4'd0);

        check("oe_change_while_scl_high", oe_glitch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_tx.md
Name: i2c_slave_tx

Overview:
- I2C slave transmitter: the read-direction responder on the shared SCL/SDA bus.
- Monitors master-driven SCL/SDA and detects START/STOP.
- On an address match with R/W=1, ACKs and serialises bytes from a local source onto SDA, MSB first, until the master NACKs or issues STOP.
- Sits beside the existing master and write-slave in the I2C top level and drives SDA through the same sda_out/sda_oe tri-state scheme.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this block answers to.

Ports:
- clk  input  1  system clock, oversamples SCL (clk >= 8x SCL rate).
- reset  input  1  synchronous, active-high reset.
- scl  input  1  bus clock from master.
- sda_in  input  1  bus SDA level (read back from the inout).
- tx_data  input  8  next byte to transmit; must be stable when tx_ack pulses.
- sda_out  output  1  SDA drive value; always 0 when sda_oe=1 (open-drain).
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- tx_ack  output  1  one-cycle pulse: tx_data was captured into the shift register.
- nack_seen  output  1  one-cycle pulse: master NACKed a transmitted byte.
- busy  output  1  high from START with a matching read address until STOP or NACK completion.
- state  output  4  current FSM state encoding.

Behaviour:
- Reset values:
  - sda_oe=0, sda_out=0, tx_ack=0, nack_seen=0, busy=0.
  - state=IDLE(0); shift register and bit counter cleared.
  - Reset mid-transfer releases SDA on the first clk after reset is asserted. The next transaction needs a fresh START.
- Input conditioning:
  - scl and sda_in each pass through a 2-flop synchroniser, then a previous-value register.
  - Edge events are single-cycle and lag the pins by 3 clk.
  - scl_rise = synced 0->1; scl_fall = synced 1->0.
  - START = synced SDA 1->0 while synced SCL=1.
  - STOP = synced SDA 0->1 while synced SCL=1.
- Global priority:
  - STOP in any state -> IDLE, sda_oe=0, busy=0.
  - START in any state -> ADDR (repeated start), bit counter=0, sda_oe=0.
  - STOP/START take precedence over a coincident scl edge.
- Bus drive timing: the slave changes sda_oe only on scl_fall, never while SCL is high. Its own drive can therefore never create a false START/STOP.
- FSM states:
  - IDLE (0): wait for START.
  - ADDR (1):
    - Shift synced SDA into addr_shift on each scl_rise; 8 bits (7 address + R/W).
    - After the 8th rise, evaluate the byte.
    - Match with R/W=1: on the next scl_fall set sda_oe=1, load tx_data into tx_shift, pulse tx_ack, set busy=1, go ADDR_ACK.
    - Address mismatch or R/W=0: go WAIT_STOP; SDA stays released (no ACK).
  - ADDR_ACK (2): hold SDA low through the ACK clock. On the following scl_fall, drive the MSB (sda_oe = ~tx_shift[7]), bit counter=0, go TX_BYTE.
  - TX_BYTE (3):
    - On each scl_fall, shift left and drive the next bit. A 1 releases SDA, a 0 pulls it low.
    - After the 8th bit's scl_fall: sda_oe=0, go WAIT_ACK.
  - WAIT_ACK (4): sample synced SDA on scl_rise.
    - 0 (ACK): on the next scl_fall, load tx_data, pulse tx_ack, drive its MSB, go TX_BYTE.
    - 1 (NACK): pulse nack_seen, busy=0, go WAIT_STOP.
  - WAIT_STOP (5): SDA released; ignore bits; leave only on STOP (-> IDLE) or START (-> ADDR).
- Counters: 3-bit bit counter, wraps 7->0 at byte boundary; no byte-count limit.
- tx_ack fires exactly once per byte transmitted, including the first byte at the address ACK. The source may update tx_data any time after the pulse.

Test Plan:
- START, master clocks 0xA1 (addr 0x50, read), tx_data=0x3C -> slave pulls SDA low in ACK slot, tx_ack pulses once. SDA on successive scl_rise reads 0,0,1,1,1,1,0,0; busy=1.
- Continue with master ACK, tx_data=0xC5, then master NACK, then STOP -> second tx_ack pulse and SDA bits 1,1,0,0,0,1,0,1. nack_seen pulses on the NACK rise, then sda_oe=0, state WAIT_STOP -> IDLE on STOP, busy=0.
- START with 0xA0 (matching address, write) and with 0xA3 (addr 0x51, read) -> SDA never driven in the ACK slot. Both go to state 5; no tx_ack.
- Repeated START mid-byte (during TX_BYTE bit 4) followed by 0xA1 -> SDA released, state ADDR, then fresh ACK and transmission of the current tx_data.
- Assert reset for 1 clk while driving a 0 bit -> sda_oe=0 and state=0 next cycle. A subsequent full 0xA1 read transaction completes normally.
- Byte of all ones, tx_data=0xFF -> sda_oe stays 0 for all 8 bit slots. Byte 0x00 -> sda_oe=1 for all 8 slots, released exactly at the 8th-bit scl_fall.
